// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between the instruction-fetch and data ports.
// Each access runs IDLE -> ACCESS -> WAIT x RD_LAT (reads only) -> RESP, and the response ends with a one-cycle ack.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_data_q, gnt_data_d;
    logic              we_q, we_d;
    logic              last_data_q, last_data_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;
    logic              pick_data;

    // Data wins if it is the only requester, or on a tie when fetch was granted last.
    assign pick_data = d_req && (!if_req || !last_data_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_data_d  = gnt_data_q;
        we_d        = we_q;
        last_data_d = last_data_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    gnt_data_d  = pick_data;
                    last_data_d = pick_data;
                    we_d        = pick_data && d_we;
                    ram_addr_d  = pick_data ? d_addr : if_addr;
                    if (pick_data) begin
                        ram_wdata_d = d_wdata;
                    end
                    ram_en_d    = 1'b1;
                    ram_we_d    = pick_data && d_we;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    d_ack_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Last wait cycle is the one in which ram_rdata is valid.
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    if (gnt_data_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = ram_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = ram_rdata;
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gnt_data_q  <= 1'b0;
            we_q        <= 1'b0;
            last_data_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_data_q  <= gnt_data_d;
            we_q        <= we_d;
            last_data_q <= last_data_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance for each of RD_LAT = 2, 1 and 4.
// Each instance has its own behavioural RAM model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 32;
    localparam int unsigned NI = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          if_req    [NI];
    logic [AW-1:0] if_addr   [NI];
    logic          if_ack    [NI];
    logic [DW-1:0] if_rdata  [NI];
    logic          d_req     [NI];
    logic          d_we      [NI];
    logic [AW-1:0] d_addr    [NI];
    logic [DW-1:0] d_wdata   [NI];
    logic          d_ack     [NI];
    logic [DW-1:0] d_rdata   [NI];
    logic          ram_en    [NI];
    logic          ram_we    [NI];
    logic [AW-1:0] ram_addr  [NI];
    logic [DW-1:0] ram_wdata [NI];
    logic [DW-1:0] ram_rdata [NI];
    logic          busy      [NI];

    logic [DW-1:0] exp_if [NI];
    logic [DW-1:0] exp_d  [NI];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int unsigned LAT = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
        logic [DW-1:0] mem  [256];
        logic [DW-1:0] pipe [LAT];

        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .if_req    (if_req[k]),
            .if_addr   (if_addr[k]),
            .if_ack    (if_ack[k]),
            .if_rdata  (if_rdata[k]),
            .d_req     (d_req[k]),
            .d_we      (d_we[k]),
            .d_addr    (d_addr[k]),
            .d_wdata   (d_wdata[k]),
            .d_ack     (d_ack[k]),
            .d_rdata   (d_rdata[k]),
            .ram_en    (ram_en[k]),
            .ram_we    (ram_we[k]),
            .ram_addr  (ram_addr[k]),
            .ram_wdata (ram_wdata[k]),
            .ram_rdata (ram_rdata[k]),
            .busy      (busy[k])
        );

        initial begin
            for (int i = 0; i < 256; i++) begin
                mem[i] = (i == 16) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
            end
        end

        // Read data is valid exactly LAT cycles after the ram_en cycle; filler otherwise.
        always @(posedge clk) begin
            if (ram_en[k] && ram_we[k]) mem[ram_addr[k][7:0]] <= ram_wdata[k];
            pipe[0] <= (ram_en[k] && !ram_we[k]) ? mem[ram_addr[k][7:0]] : 32'hBAD00000;
            for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
        end
        assign ram_rdata[k] = pipe[LAT-1];
    end

    // Starts with cycle 0 (request visible at the next edge); ends #1 after the edge of cycle ack_cyc+1.
    task automatic run_txn(input int k, input bit is_d, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] exp,
                           input int ack_cyc, input string nm);
        if (is_d) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
        end else begin
            if_req[k] = 1'b1; if_addr[k] = addr;
        end
        for (int c = 1; c <= ack_cyc + 1; c++) begin
            @(posedge clk); #1;
            if (c == ack_cyc + 1) begin
                if_req[k] = 1'b0; d_req[k] = 1'b0;
            end
            checks++;
            if (ram_en[k] !== (c == 1)) begin
                failures++; $display("FAIL %s c%0d ram_en=%b exp=%b", nm, c, ram_en[k], (c == 1));
            end
            checks++;
            if (ram_we[k] !== (c == 1 && is_d && we)) begin
                failures++; $display("FAIL %s c%0d ram_we=%b exp=%b", nm, c, ram_we[k], (c == 1 && is_d && we));
            end
            checks++;
            if (busy[k] !== (c <= ack_cyc)) begin
                failures++; $display("FAIL %s c%0d busy=%b exp=%b", nm, c, busy[k], (c <= ack_cyc));
            end
            checks++;
            if (if_ack[k] !== (!is_d && c == ack_cyc)) begin
                failures++; $display("FAIL %s c%0d if_ack=%b exp=%b", nm, c, if_ack[k], (!is_d && c == ack_cyc));
            end
            checks++;
            if (d_ack[k] !== (is_d && c == ack_cyc)) begin
                failures++; $display("FAIL %s c%0d d_ack=%b exp=%b", nm, c, d_ack[k], (is_d && c == ack_cyc));
            end
            if (c == 1) begin
                checks++;
                if (ram_addr[k] !== addr) begin
                    failures++; $display("FAIL %s ram_addr=%h exp=%h", nm, ram_addr[k], addr);
                end
                if (is_d && we) begin
                    checks++;
                    if (ram_wdata[k] !== wdata) begin
                        failures++; $display("FAIL %s ram_wdata=%h exp=%h", nm, ram_wdata[k], wdata);
                    end
                end
            end
            if (c == ack_cyc && !(is_d && we)) begin
                if (is_d) exp_d[k] = exp;
                else exp_if[k] = exp;
            end
            if (c >= ack_cyc) begin
                checks++;
                if (if_rdata[k] !== exp_if[k]) begin
                    failures++; $display("FAIL %s c%0d if_rdata=%h exp=%h", nm, c, if_rdata[k], exp_if[k]);
                end
                checks++;
                if (d_rdata[k] !== exp_d[k]) begin
                    failures++; $display("FAIL %s c%0d d_rdata=%h exp=%h", nm, c, d_rdata[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        for (int k = 0; k < int'(NI); k++) begin
            checks++;
            if ({if_ack[k], d_ack[k], ram_en[k], ram_we[k], busy[k]} !== 5'b0) begin
                failures++;
                $display("FAIL reset_ctl k%0d if_ack=%b d_ack=%b ram_en=%b ram_we=%b busy=%b exp=0",
                         k, if_ack[k], d_ack[k], ram_en[k], ram_we[k], busy[k]);
            end
            checks++;
            if ({ram_addr[k], ram_wdata[k], if_rdata[k], d_rdata[k]} !== '0) begin
                failures++;
                $display("FAIL reset_data k%0d ram_addr=%h ram_wdata=%h if_rdata=%h d_rdata=%h exp=0",
                         k, ram_addr[k], ram_wdata[k], if_rdata[k], d_rdata[k]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < int'(NI); k++) begin
                checks++;
                if (ram_en[k] !== 1'b0 || busy[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL idle k%0d c%0d ram_en=%b busy=%b exp=0 0", k, c, ram_en[k], busy[k]);
                end
            end
        end
    endtask

    task automatic test_fetch();
        run_txn(0, 1'b0, 1'b0, 15'h010, 32'h0, 32'hDEADBEEF, 4, "fetch_lat2");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (if_rdata[0] !== 32'hDEADBEEF || ram_en[0] !== 1'b0) begin
                failures++;
                $display("FAIL fetch_hold c%0d if_rdata=%h ram_en=%b exp=deadbeef 0", c, if_rdata[0], ram_en[0]);
            end
        end
    endtask

    task automatic test_write();
        run_txn(0, 1'b1, 1'b1, 15'h020, 32'h12345678, 32'h0, 2, "write");
        run_txn(0, 1'b0, 1'b0, 15'h020, 32'h0, 32'h12345678, 4, "fetch_written");
    endtask

    task automatic test_back_to_back();
        int n_grant  = 0;
        int n_ack    = 0;
        int last_ack = -1;
        int cyc      = 0;
        bit cur_d;
        d_we[0] = 1'b0; d_addr[0] = 15'h030; if_addr[0] = 15'h010;
        d_req[0] = 1'b1; if_req[0] = 1'b1;
        while (n_ack < 8 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            checks++;
            if (if_ack[0] && d_ack[0]) begin
                failures++; $display("FAIL b2b_overlap cyc%0d if_ack=1 d_ack=1 exp one-hot", cyc);
            end
            if (ram_en[0]) begin
                cur_d = (ram_addr[0] == 15'h030);
                checks++;
                if (cur_d !== (n_grant % 2 == 0)) begin
                    failures++; $display("FAIL b2b_order grant%0d data=%b exp=%b", n_grant, cur_d, (n_grant % 2 == 0));
                end
                checks++;
                if (cyc != last_ack + 2) begin
                    failures++; $display("FAIL b2b_gap grant%0d cyc=%0d exp=%0d", n_grant, cyc, last_ack + 2);
                end
                n_grant++;
            end
            if (d_ack[0]) begin
                checks++;
                if (d_rdata[0] !== 32'hC0DE0030) begin
                    failures++; $display("FAIL b2b_d_rdata d_rdata=%h exp=c0de0030", d_rdata[0]);
                end
                n_ack++; last_ack = cyc;
            end
            if (if_ack[0]) begin
                checks++;
                if (if_rdata[0] !== 32'hDEADBEEF) begin
                    failures++; $display("FAIL b2b_if_rdata if_rdata=%h exp=deadbeef", if_rdata[0]);
                end
                n_ack++; last_ack = cyc;
            end
        end
        checks++;
        if (n_ack != 8 || n_grant != 8) begin
            failures++; $display("FAIL b2b_count acks=%0d grants=%0d exp=8 8", n_ack, n_grant);
        end
        @(posedge clk); #1;
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ram_en[0] !== 1'b0 || busy[0] !== 1'b0) begin
            failures++; $display("FAIL b2b_drain ram_en=%b busy=%b exp=0 0", ram_en[0], busy[0]);
        end
        exp_d[0]  = 32'hC0DE0030;
        exp_if[0] = 32'hDEADBEEF;
    endtask

    task automatic test_reset_mid();
        if_addr[0] = 15'h010; if_req[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy[0] !== 1'b1) begin
            failures++; $display("FAIL rst_mid_pre busy=%b exp=1", busy[0]);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({ram_en[0], ram_we[0], if_ack[0], d_ack[0], busy[0]} !== 5'b0) begin
            failures++;
            $display("FAIL rst_mid_ctl ram_en=%b ram_we=%b if_ack=%b d_ack=%b busy=%b exp=0",
                     ram_en[0], ram_we[0], if_ack[0], d_ack[0], busy[0]);
        end
        checks++;
        if (if_rdata[0] !== 32'h0 || d_rdata[0] !== 32'h0) begin
            failures++; $display("FAIL rst_mid_rdata if_rdata=%h d_rdata=%h exp=0 0", if_rdata[0], d_rdata[0]);
        end
        if_req[0] = 1'b0;
        for (int k = 0; k < int'(NI); k++) begin
            exp_if[k] = '0; exp_d[k] = '0;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            checks++;
            if (if_ack[0] !== 1'b0 || ram_en[0] !== 1'b0) begin
                failures++; $display("FAIL rst_mid_quiet c%0d if_ack=%b ram_en=%b exp=0 0", c, if_ack[0], ram_en[0]);
            end
        end
        run_txn(0, 1'b1, 1'b0, 15'h020, 32'h0, 32'h12345678, 4, "d_after_reset");
    endtask

    task automatic test_rd_lat();
        run_txn(1, 1'b0, 1'b0, 15'h010, 32'h0, 32'hDEADBEEF, 3, "fetch_lat1");
        run_txn(2, 1'b0, 1'b0, 15'h010, 32'h0, 32'hDEADBEEF, 6, "fetch_lat4");
    endtask

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < int'(NI); k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
            exp_if[k] = '0; exp_d[k] = '0;
        end
        test_reset();
        test_fetch();
        test_write();
        test_back_to_back();
        test_reset_mid();
        test_rd_lat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
